// File: rtl/vector_bias_unit_if.sv
// Bus between the controller and vector_bias_unit: start/mode/mask/vectors in, result vector and status out.
interface vector_bias_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_UNITS  = 64
);
  logic                                  start;
  logic [1:0]                            mode;
  logic [NUM_UNITS-1:0]                  active_units;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  In_x;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  In_bias;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  Out;
  logic                                  busy;
  logic                                  ready;

  modport master (
    output start, mode, active_units, In_x, In_bias,
    input  Out, busy, ready
  );

  modport slave (
    input  start, mode, active_units, In_x, In_bias,
    output Out, busy, ready
  );
endinterface

// File: rtl/vector_bias_unit.sv
// Per-lane bias add/sub with optional ReLU, LANES adders time-multiplexed over NUM_UNITS/LANES beats.
// Build option: define VECTOR_BIAS_SAT_EN to saturate results instead of wrapping.
module vector_bias_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_UNITS  = 64,
  parameter int LANES      = 8
) (
  input  logic              clk,
  input  logic              reset,
  vector_bias_unit_if.slave bus
);
  localparam int BEATS = NUM_UNITS / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int UW    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_ADD_RELU = 2'd2, OP_PASS = 2'd3} op_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] vec_t;

  state_e               state_q, state_d;
  logic [BW-1:0]        beat_q;
  op_e                  mode_q;
  logic [NUM_UNITS-1:0] mask_q;
  vec_t                 x_q, b_q, out_q;

  logic [LANES-1:0][UW-1:0]         lane_idx;
  logic [LANES-1:0][DATA_WIDTH-1:0] lane_res;

  // Operands are sign-extended by one bit so the raw sum never overflows before reduction.
  function automatic logic [DATA_WIDTH-1:0] lane_op(input op_e op, input logic en,
                                                     input logic [DATA_WIDTH-1:0] x,
                                                     input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0]   xe, be, sum;
    logic [DATA_WIDTH-1:0] red;
    xe = {x[DATA_WIDTH-1], x};
    be = {b[DATA_WIDTH-1], b};
    case (op)
      OP_SUB:  sum = xe - be;
      OP_PASS: sum = xe;
      default: sum = xe + be;
    endcase
`ifdef VECTOR_BIAS_SAT_EN
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
      red = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      red = sum[DATA_WIDTH-1:0];
`else
    red = sum[DATA_WIDTH-1:0];
`endif
    if (op == OP_ADD_RELU && red[DATA_WIDTH-1])
      red = '0;
    if (!en)
      red = '0;
    return red;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (beat_q == BW'(BEATS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_idx[l] = UW'(32'(beat_q) * 32'(LANES) + l);
      lane_res[l] = lane_op(mode_q, mask_q[lane_idx[l]], x_q[lane_idx[l]], b_q[lane_idx[l]]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      mode_q  <= OP_ADD;
      mask_q  <= '0;
      x_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_q <= op_e'(bus.mode);
            mask_q <= bus.active_units;
            x_q    <= bus.In_x;
            b_q    <= bus.In_bias;
            beat_q <= '0;
          end
        end
        RUN: begin
          for (int unsigned l = 0; l < LANES; l++)
            out_q[lane_idx[l]] <= lane_res[l];
          beat_q <= (beat_q == BW'(BEATS - 1)) ? '0 : beat_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Out   = out_q;
  assign bus.busy  = (state_q == RUN) || (state_q == DONE);
  assign bus.ready = (state_q == DONE);
endmodule

// File: tb/tb_vector_bias_unit.sv
// Self-checking bench for vector_bias_unit against an integer-arithmetic reference model.
module tb_vector_bias_unit;
  localparam int DW    = 16;
  localparam int NU    = 64;
  localparam int LN    = 8;
  localparam int BEATS = NU / LN;
  localparam int MAXV  = (1 << (DW - 1)) - 1;
  localparam int MINV  = -(1 << (DW - 1));

  typedef logic [NU-1:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  vector_bias_unit_if #(.DATA_WIDTH(DW), .NUM_UNITS(NU)) bus ();

  vector_bias_unit #(.DATA_WIDTH(DW), .NUM_UNITS(NU), .LANES(LN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   rdy_at, rdy_cnt, busy_cnt;
  vec_t mid_out, done_out, last_exp;

  function automatic logic [DW-1:0] ref_lane(input logic [1:0] m, input logic en,
                                             input logic [DW-1:0] x, input logic [DW-1:0] b);
    int xi, bi, r;
    if (!en) return '0;
    xi = int'($signed(x));
    bi = int'($signed(b));
    case (m)
      2'd1:    r = xi - bi;
      2'd3:    r = xi;
      default: r = xi + bi;
    endcase
`ifdef VECTOR_BIAS_SAT_EN
    if (r > MAXV) r = MAXV;
    if (r < MINV) r = MINV;
`else
    r = r & ((1 << DW) - 1);
    if (r > MAXV) r = r - (1 << DW);
`endif
    if (m == 2'd2 && r < 0) r = 0;
    return DW'(r);
  endfunction

  function automatic vec_t ref_vec(input logic [1:0] m, input logic [NU-1:0] mask,
                                   input vec_t x, input vec_t b);
    vec_t v;
    for (int i = 0; i < NU; i++) v[i] = ref_lane(m, mask[i], x[i], b[i]);
    return v;
  endfunction

  function automatic vec_t fill(input logic [DW-1:0] v);
    vec_t r;
    for (int i = 0; i < NU; i++) r[i] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] pick_val();
    logic [DW-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 16'h7FFF;
      1:       v = 16'h8000;
      2:       v = 16'h0000;
      3:       v = 16'hFFFF;
      default: v = DW'($urandom);
    endcase
    return v;
  endfunction

  // Runs one operation and records timing plus the Out snapshots after beat 0 and at ready.
  task automatic do_op(input logic [1:0] m, input logic [NU-1:0] mask, input vec_t x, input vec_t b,
                       input bit restart_mid, input bit scramble);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.active_units = mask; bus.In_x = x; bus.In_bias = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (scramble) begin
      bus.mode = 2'($urandom);
      bus.active_units = {$urandom, $urandom};
      for (int i = 0; i < NU; i++) begin
        bus.In_x[i] = DW'($urandom);
        bus.In_bias[i] = DW'($urandom);
      end
    end
    rdy_at = -1; rdy_cnt = 0; busy_cnt = 0;
    for (int n = 0; n <= BEATS + 3; n++) begin
      if (n > 0) begin
        bus.start = restart_mid && (n == 3);
        @(posedge clk); #1;
      end
      if (bus.busy) busy_cnt++;
      if (bus.ready) begin
        rdy_cnt++;
        if (rdy_at < 0) begin
          rdy_at = n;
          done_out = bus.Out;
        end
      end
      if (n == 1) mid_out = bus.Out;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.Out !== '0) begin errors++; $display("FAIL reset_out: got nonzero Out, required all 0"); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", bus.ready); end
    @(negedge clk); reset = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_start_leak: busy got %b required 0", bus.busy); end
  endtask

  task automatic test_basic_add();
    vec_t e = fill(16'h0003);
    do_op(2'd0, '1, fill(16'h0001), fill(16'h0002), 1'b0, 1'b0);
    checks++; if (rdy_at !== BEATS) begin errors++; $display("FAIL basic_latency: ready at %0d required %0d", rdy_at, BEATS); end
    checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL basic_ready_count: got %0d required 1", rdy_cnt); end
    checks++; if (busy_cnt !== BEATS + 1) begin errors++; $display("FAIL basic_busy_cycles: got %0d required %0d", busy_cnt, BEATS + 1); end
    for (int i = 0; i < NU; i++) begin
      checks++; if (done_out[i] !== e[i]) begin errors++; $display("FAIL basic_add lane %0d: got %h required %h", i, done_out[i], e[i]); end
    end
    last_exp = e;
  endtask

  task automatic test_overflow();
`ifdef VECTOR_BIAS_SAT_EN
    logic [DW-1:0] e_add = 16'h7FFF, e_sub = 16'h8000;
`else
    logic [DW-1:0] e_add = 16'h8000, e_sub = 16'h7FFF;
`endif
    do_op(2'd0, '1, fill(16'h7FFF), fill(16'h0001), 1'b0, 1'b0);
    for (int i = 0; i < NU; i++) begin
      checks++; if (done_out[i] !== e_add) begin errors++; $display("FAIL ovf_add lane %0d: got %h required %h", i, done_out[i], e_add); end
    end
    do_op(2'd1, '1, fill(16'h8000), fill(16'h0001), 1'b0, 1'b0);
    for (int i = 0; i < NU; i++) begin
      checks++; if (done_out[i] !== e_sub) begin errors++; $display("FAIL ovf_sub lane %0d: got %h required %h", i, done_out[i], e_sub); end
    end
    last_exp = fill(e_sub);
  endtask

  task automatic test_relu_pass();
    do_op(2'd2, '1, fill(16'hFFF0), fill(16'h0005), 1'b0, 1'b0);
    for (int i = 0; i < NU; i++) begin
      checks++; if (done_out[i] !== 16'h0000) begin errors++; $display("FAIL relu_neg lane %0d: got %h required 0000", i, done_out[i]); end
    end
    do_op(2'd2, '1, fill(16'h0010), fill(16'h0005), 1'b0, 1'b0);
    for (int i = 0; i < NU; i++) begin
      checks++; if (done_out[i] !== 16'h0015) begin errors++; $display("FAIL relu_pos lane %0d: got %h required 0015", i, done_out[i]); end
    end
    do_op(2'd3, '1, fill(16'h1234), fill(16'h7777), 1'b0, 1'b0);
    for (int i = 0; i < NU; i++) begin
      checks++; if (done_out[i] !== 16'h1234) begin errors++; $display("FAIL pass lane %0d: got %h required 1234", i, done_out[i]); end
    end
    last_exp = fill(16'h1234);
  endtask

  task automatic test_masking();
    logic [DW-1:0] e;
    do_op(2'd0, 64'h000000000000000F, fill(16'h0001), fill(16'h0002), 1'b0, 1'b0);
    for (int i = 0; i < NU; i++) begin
      e = (i < 4) ? 16'h0003 : 16'h0000;
      checks++; if (done_out[i] !== e) begin errors++; $display("FAIL mask lane %0d: got %h required %h", i, done_out[i], e); end
      last_exp[i] = e;
    end
  endtask

  task automatic test_handshake();
    vec_t x, b, e;
    for (int i = 0; i < NU; i++) begin x[i] = DW'($urandom); b[i] = DW'($urandom); end
    e = ref_vec(2'd1, '1, x, b);
    do_op(2'd1, '1, x, b, 1'b1, 1'b0);
    checks++; if (rdy_at !== BEATS) begin errors++; $display("FAIL restart_latency: ready at %0d required %0d", rdy_at, BEATS); end
    checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL restart_ready_count: got %0d required 1", rdy_cnt); end
    for (int i = 0; i < NU; i++) begin
      checks++; if (done_out[i] !== e[i]) begin errors++; $display("FAIL restart lane %0d: got %h required %h", i, done_out[i], e[i]); end
    end
    e = ref_vec(2'd2, 64'hF0F0_FFFF_0000_AAAA, x, b);
    do_op(2'd2, 64'hF0F0_FFFF_0000_AAAA, x, b, 1'b0, 1'b1);
    for (int i = 0; i < NU; i++) begin
      checks++; if (done_out[i] !== e[i]) begin errors++; $display("FAIL capture lane %0d: got %h required %h", i, done_out[i], e[i]); end
    end
    last_exp = e;
  endtask

  task automatic test_reset_midrun();
    int rcnt = 0;
    vec_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'd0; bus.active_units = '1;
    bus.In_x = fill(16'h0100); bus.In_bias = fill(16'h0011);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.Out !== '0) begin errors++; $display("FAIL midrun_reset_out: got nonzero Out, required all 0"); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy: got %b required 0", bus.busy); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL midrun_reset_ready: got %b required 0", bus.ready); end
    @(negedge clk); reset = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.ready) rcnt++;
    end
    checks++; if (rcnt !== 0) begin errors++; $display("FAIL midrun_no_ready: got %0d pulses required 0", rcnt); end
    e = fill(16'h0111);
    do_op(2'd0, '1, fill(16'h0100), fill(16'h0011), 1'b0, 1'b0);
    checks++; if (rdy_at !== BEATS) begin errors++; $display("FAIL post_reset_latency: ready at %0d required %0d", rdy_at, BEATS); end
    for (int i = 0; i < NU; i++) begin
      checks++; if (done_out[i] !== e[i]) begin errors++; $display("FAIL post_reset lane %0d: got %h required %h", i, done_out[i], e[i]); end
    end
    last_exp = e;
  endtask

  task automatic test_random();
    vec_t x, b, e;
    logic [1:0] m;
    logic [NU-1:0] mask;
    for (int t = 0; t < 20; t++) begin
      m = 2'($urandom);
      mask = {$urandom, $urandom};
      if (t % 4 == 0) mask = '1;
      for (int i = 0; i < NU; i++) begin x[i] = pick_val(); b[i] = pick_val(); end
      e = ref_vec(m, mask, x, b);
      do_op(m, mask, x, b, 1'b0, 1'b0);
      checks++; if (rdy_at !== BEATS) begin errors++; $display("FAIL rand_latency op %0d: ready at %0d required %0d", t, rdy_at, BEATS); end
      for (int i = 0; i < NU; i++) begin
        checks++;
        if (mid_out[i] !== ((i < LN) ? e[i] : last_exp[i])) begin
          errors++;
          $display("FAIL rand_beat0 op %0d lane %0d: got %h required %h", t, i, mid_out[i], (i < LN) ? e[i] : last_exp[i]);
        end
        checks++; if (done_out[i] !== e[i]) begin errors++; $display("FAIL rand_done op %0d lane %0d: got %h required %h", t, i, done_out[i], e[i]); end
        checks++; if (bus.Out[i] !== e[i]) begin errors++; $display("FAIL rand_hold op %0d lane %0d: got %h required %h", t, i, bus.Out[i], e[i]); end
      end
      last_exp = e;
    end
  endtask

  task automatic test_back_to_back();
    vec_t xa, xb, ea, eb;
    int r1 = -1, r2 = -1, rc = 0;
    vec_t o1, o2;
    for (int i = 0; i < NU; i++) begin xa[i] = DW'($urandom); xb[i] = DW'($urandom); end
    ea = ref_vec(2'd0, '1, xa, fill(16'h0003));
    eb = ref_vec(2'd1, '1, xb, fill(16'h0007));
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'd0; bus.active_units = '1; bus.In_x = xa; bus.In_bias = fill(16'h0003);
    @(posedge clk); #1;
    bus.mode = 2'd1; bus.In_x = xb; bus.In_bias = fill(16'h0007);
    for (int n = 1; n <= 2 * BEATS + 4; n++) begin
      @(posedge clk); #1;
      if (n == BEATS + 2) bus.start = 1'b0;
      if (bus.ready) begin
        rc++;
        if (r1 < 0) begin r1 = n; o1 = bus.Out; end
        else if (r2 < 0) begin r2 = n; o2 = bus.Out; end
      end
    end
    bus.start = 1'b0;
    checks++; if (rc !== 2) begin errors++; $display("FAIL b2b_ready_count: got %0d required 2", rc); end
    checks++; if (r1 !== BEATS) begin errors++; $display("FAIL b2b_first_ready: at %0d required %0d", r1, BEATS); end
    checks++; if (r2 !== 2 * BEATS + 2) begin errors++; $display("FAIL b2b_second_ready: at %0d required %0d", r2, 2 * BEATS + 2); end
    for (int i = 0; i < NU; i++) begin
      checks++; if (o1[i] !== ea[i]) begin errors++; $display("FAIL b2b_op1 lane %0d: got %h required %h", i, o1[i], ea[i]); end
      checks++; if (o2[i] !== eb[i]) begin errors++; $display("FAIL b2b_op2 lane %0d: got %h required %h", i, o2[i], eb[i]); end
    end
    last_exp = eb;
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 2'd0; bus.active_units = '0; bus.In_x = '0; bus.In_bias = '0;
    last_exp = '0;
    test_reset();
    test_basic_add();
    test_overflow();
    test_relu_pass();
    test_masking();
    test_handshake();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
